// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the IF/MEM memory port arbiter: default bus widths,
//   the arbiter FSM state type and the all-ones byte-enable pattern used for
//   every read transaction.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Wide enough for data buses up to 1024 bits; users slice off the
    // low DATA_W/8 bits they need.
    localparam int                    BE_W_MAX    = 128;
    localparam logic [BE_W_MAX-1:0]   BE_ALL_ONES = '1;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUS_IF  = 2'd1,
        ARB_BUS_MEM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported memory bus between the instruction fetch (IF)
//   stage and the data (MEM) stage. A granted request is registered onto the
//   bus and held until bus_ready; read data returns to the requester with a
//   one-cycle valid pulse. MEM always wins a tie because it belongs to the
//   older instruction.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   if_req/if_addr/if_flush        fetch request, address, squash
//   if_rdata/if_valid              fetched word and completion pulse
//   mem_req/we/be/addr/wdata       data request (load or store)
//   mem_rdata/mem_valid            load data and completion pulse
//   bus_req/we/be/addr/wdata       registered memory bus request
//   bus_ready/bus_rdata            memory completion and read data
//   stall_if/stall_mem             hold signals for the pipeline hazard unit
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,

    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [DATA_W/8-1:0]   mem_be,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_valid,

    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_W/8-1:0]   bus_be,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ready,
    input  logic [DATA_W-1:0]     bus_rdata,

    output logic                  stall_if,
    output logic                  stall_mem
);

    localparam int               BE_W    = DATA_W / 8;
    localparam logic [BE_W-1:0]  BE_ONES = BE_ALL_ONES[BE_W-1:0];

    arb_state_t state;
    logic       drop;

    // A requester whose valid is pulsing this cycle has just been served; its
    // still-asserted req must not start a second transaction.
    logic mem_grantable;
    logic if_grantable;

    assign mem_grantable = mem_req & ~mem_valid;
    assign if_grantable  = if_req & ~if_flush & ~if_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            drop      <= 1'b0;
        end else begin
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (mem_grantable) begin
                        state     <= ARB_BUS_MEM;
                        bus_req   <= 1'b1;
                        bus_we    <= mem_we;
                        bus_be    <= mem_we ? mem_be : BE_ONES;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                    end else if (if_grantable) begin
                        state     <= ARB_BUS_IF;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_be    <= BE_ONES;
                        bus_addr  <= if_addr;
                        drop      <= 1'b0;
                    end
                end

                ARB_BUS_IF: begin
                    // The bus cycle cannot be aborted, so a flush only marks
                    // the result as unwanted. A flush in the completion cycle
                    // itself must also suppress the return.
                    if (if_flush) begin
                        drop <= 1'b1;
                    end
                    if (bus_ready) begin
                        state   <= ARB_IDLE;
                        bus_req <= 1'b0;
                        if (!drop && !if_flush) begin
                            if_rdata <= bus_rdata;
                            if_valid <= 1'b1;
                        end
                    end
                end

                ARB_BUS_MEM: begin
                    if (bus_ready) begin
                        state     <= ARB_IDLE;
                        bus_req   <= 1'b0;
                        mem_valid <= 1'b1;
                        if (!bus_we) begin
                            mem_rdata <= bus_rdata;
                        end
                    end
                end

                default: begin
                    state   <= ARB_IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

    // Purely from request/valid/flush so the hazard unit never sees a
    // combinational path from the memory's bus_ready.
    assign stall_if  = if_req & ~if_valid & ~if_flush;
    assign stall_mem = mem_req & ~mem_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed timing scenarios followed by a randomized phase in which IF and
//   MEM requester agents and a variable-latency memory run against a
//   transaction-level reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int REQS       = 1000;
    localparam int RAND_LIMIT = 40000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               if_req;
    logic [ADDR_W-1:0]  if_addr;
    logic               if_flush;
    logic [DATA_W-1:0]  if_rdata;
    logic               if_valid;
    logic               mem_req;
    logic               mem_we;
    logic [3:0]         mem_be;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata;
    logic               mem_valid;
    logic               bus_req;
    logic               bus_we;
    logic [3:0]         bus_be;
    logic [ADDR_W-1:0]  bus_addr;
    logic [DATA_W-1:0]  bus_wdata;
    logic               bus_ready;
    logic [DATA_W-1:0]  bus_rdata;
    logic               stall_if;
    logic               stall_mem;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_be    (bus_be),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 clk = ~clk;

    // Advance n clock cycles; returns 1 time unit after the last rising edge.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model state for the randomized phase
    logic [31:0] mem_model [16];
    int          if_issued, if_flushed, mem_issued;
    int          dut_if_valids, dut_mem_valids;
    bit          if_active, mem_active;
    int          owner;
    int          lat_cnt;
    bit          txn_flushed, txn_we;
    logic [3:0]  txn_be;
    logic [31:0] txn_addr, txn_wdata;
    bit          e_bus, pe_bus, p_ready;
    bit          exp_if_valid, exp_mem_valid, cur_if_v, cur_mem_v;
    logic [31:0] exp_if_rdata, exp_mem_rdata;
    bit          p_if_req, p_if_flush, p_if_valid;
    bit          p_mem_req, p_mem_we, p_mem_valid;
    logic [3:0]  p_mem_be;
    logic [31:0] p_if_addr, p_mem_addr, p_mem_wdata;
    logic [31:0] rd;
    bit          finished;
    int          cyc;

    initial begin
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        if_flush  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        bus_ready = 1'b0;
        bus_rdata = '0;

        // ---------------- reset state ----------------
        applyStimulus(2);
        checkOutput("rst_bus_req",   bus_req,   0);
        checkOutput("rst_bus_be",    bus_be,    0);
        checkOutput("rst_if_valid",  if_valid,  0);
        checkOutput("rst_mem_valid", mem_valid, 0);
        checkOutput("rst_if_rdata",  if_rdata,  0);
        checkOutput("rst_mem_rdata", mem_rdata, 0);
        #3 rst_n = 1'b1;
        applyStimulus(1);

        // ---------------- fetch only, ready tied high ----------------
        $display("[TB] fetch with zero-latency memory");
        if_req    = 1'b1;
        if_addr   = 32'h0000_0010;
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0013;
        #1 checkOutput("f1_stall_if_N", stall_if, 1);
        applyStimulus(1);
        checkOutput("f1_bus_req_N1",  bus_req,  1);
        checkOutput("f1_bus_addr_N1", bus_addr, 32'h10);
        checkOutput("f1_bus_we_N1",   bus_we,   0);
        checkOutput("f1_bus_be_N1",   bus_be,   4'hF);
        checkOutput("f1_if_valid_N1", if_valid, 0);
        checkOutput("f1_stall_if_N1", stall_if, 1);
        applyStimulus(1);
        checkOutput("f1_if_valid_N2", if_valid, 1);
        checkOutput("f1_if_rdata_N2", if_rdata, 32'h13);
        checkOutput("f1_stall_if_N2", stall_if, 0);
        checkOutput("f1_bus_req_N2",  bus_req,  0);
        applyStimulus(1);
        checkOutput("f1_if_valid_pulse", if_valid, 0);
        checkOutput("f1_no_regrant",     bus_req,  0);
        if_req    = 1'b0;
        bus_ready = 1'b0;
        applyStimulus(1);

        // ---------------- collision: MEM beats IF ----------------
        $display("[TB] simultaneous IF and MEM requests");
        if_req    = 1'b1;
        if_addr   = 32'h0000_0020;
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_be    = 4'hF;
        mem_addr  = 32'h0000_0100;
        applyStimulus(1);
        checkOutput("c_bus_req_N1",   bus_req,   1);
        checkOutput("c_bus_addr_N1",  bus_addr,  32'h100);
        checkOutput("c_bus_we_N1",    bus_we,    0);
        checkOutput("c_bus_be_N1",    bus_be,    4'hF);
        checkOutput("c_stall_if_N1",  stall_if,  1);
        checkOutput("c_stall_mem_N1", stall_mem, 1);
        applyStimulus(3);
        checkOutput("c_bus_held_N4", bus_req, 1);
        bus_ready = 1'b1;
        bus_rdata = 32'hCAFE_0001;
        applyStimulus(1);
        checkOutput("c_mem_valid_N5", mem_valid, 1);
        checkOutput("c_mem_rdata_N5", mem_rdata, 32'hCAFE_0001);
        checkOutput("c_if_valid_N5",  if_valid,  0);
        checkOutput("c_bus_req_N5",   bus_req,   0);
        checkOutput("c_stall_mem_N5", stall_mem, 0);
        mem_req   = 1'b0;
        bus_ready = 1'b0;
        applyStimulus(1);
        checkOutput("c_mem_valid_N6", mem_valid, 0);
        checkOutput("c_bus_req_N6",   bus_req,   1);
        checkOutput("c_bus_addr_N6",  bus_addr,  32'h20);
        applyStimulus(3);
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_1111;
        applyStimulus(1);
        checkOutput("c_if_valid_N10", if_valid, 1);
        checkOutput("c_if_rdata_N10", if_rdata, 32'h1111);
        if_req    = 1'b0;
        bus_ready = 1'b0;
        applyStimulus(1);
        checkOutput("c_if_valid_N11", if_valid, 0);

        // ---------------- store with wait states ----------------
        $display("[TB] store with wait states");
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_be    = 4'b0011;
        mem_addr  = 32'h0000_0200;
        mem_wdata = 32'hDEAD_BEEF;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("s_bus_req_N%0d", i),   bus_req,   1);
            checkOutput($sformatf("s_bus_we_N%0d", i),    bus_we,    1);
            checkOutput($sformatf("s_bus_be_N%0d", i),    bus_be,    4'b0011);
            checkOutput($sformatf("s_bus_addr_N%0d", i),  bus_addr,  32'h200);
            checkOutput($sformatf("s_bus_wdata_N%0d", i), bus_wdata, 32'hDEAD_BEEF);
            checkOutput($sformatf("s_mem_valid_N%0d", i), mem_valid, 0);
        end
        bus_ready = 1'b1;
        bus_rdata = 32'h1234_5678;
        applyStimulus(1);
        checkOutput("s_mem_valid_N4", mem_valid, 1);
        checkOutput("s_mem_rdata_N4", mem_rdata, 32'hCAFE_0001);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        bus_ready = 1'b0;
        applyStimulus(1);
        checkOutput("s_mem_valid_N5", mem_valid, 0);
        checkOutput("s_mem_rdata_N5", mem_rdata, 32'hCAFE_0001);

        // ---------------- flush while fetch is on the bus ----------------
        $display("[TB] flush during fetch");
        if_req  = 1'b1;
        if_addr = 32'h0000_0040;
        applyStimulus(1);
        checkOutput("fl_bus_req_N1",  bus_req,  1);
        checkOutput("fl_bus_addr_N1", bus_addr, 32'h40);
        applyStimulus(1);
        if_flush = 1'b1;
        #1 checkOutput("fl_stall_if_masked", stall_if, 0);
        applyStimulus(1);
        if_flush = 1'b0;
        if_addr  = 32'h0000_0080;
        applyStimulus(1);
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0099;
        applyStimulus(1);
        checkOutput("fl_if_valid_N5", if_valid, 0);
        checkOutput("fl_if_rdata_N5", if_rdata, 32'h1111);
        checkOutput("fl_bus_req_N5",  bus_req,  0);
        bus_ready = 1'b0;
        applyStimulus(1);
        checkOutput("fl_bus_req_N6",  bus_req,  1);
        checkOutput("fl_bus_addr_N6", bus_addr, 32'h80);
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0055;
        applyStimulus(1);
        checkOutput("fl_if_valid_N7", if_valid, 1);
        checkOutput("fl_if_rdata_N7", if_rdata, 32'h55);
        if_req    = 1'b0;
        bus_ready = 1'b0;
        applyStimulus(1);

        // ---------------- reset in the middle of a MEM transaction ----------------
        $display("[TB] reset mid-transaction");
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_be    = 4'hF;
        mem_addr  = 32'h0000_0300;
        mem_wdata = 32'h0BAD_F00D;
        applyStimulus(1);
        checkOutput("r_bus_req_N1", bus_req, 1);
        applyStimulus(1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("r_bus_req",   bus_req,   0);
        checkOutput("r_bus_we",    bus_we,    0);
        checkOutput("r_bus_be",    bus_be,    0);
        checkOutput("r_bus_addr",  bus_addr,  0);
        checkOutput("r_bus_wdata", bus_wdata, 0);
        checkOutput("r_if_valid",  if_valid,  0);
        checkOutput("r_mem_valid", mem_valid, 0);
        checkOutput("r_if_rdata",  if_rdata,  0);
        checkOutput("r_mem_rdata", mem_rdata, 0);
        mem_req   = 1'b0;
        mem_wdata = '0;
        applyStimulus(1);
        #3 rst_n = 1'b1;
        applyStimulus(1);
        if_req    = 1'b1;
        if_addr   = 32'h0000_0044;
        bus_ready = 1'b1;
        bus_rdata = 32'h0000_0777;
        applyStimulus(1);
        checkOutput("r2_bus_req",  bus_req,  1);
        checkOutput("r2_bus_addr", bus_addr, 32'h44);
        applyStimulus(1);
        checkOutput("r2_if_valid", if_valid, 1);
        checkOutput("r2_if_rdata", if_rdata, 32'h777);
        if_req    = 1'b0;
        bus_ready = 1'b0;
        applyStimulus(1);

        // ---------------- randomized traffic against the reference model ----------------
        $display("[TB] random traffic, %0d requests", REQS);
        for (int i = 0; i < 16; i++) mem_model[i] = $urandom;
        if_issued = 0; if_flushed = 0; mem_issued = 0;
        dut_if_valids = 0; dut_mem_valids = 0;
        if_active = 0; mem_active = 0;
        owner = 0; lat_cnt = 0; txn_flushed = 0; txn_we = 0;
        txn_be = '0; txn_addr = '0; txn_wdata = '0;
        pe_bus = 0; p_ready = 0; e_bus = 0;
        exp_if_valid = 0; exp_mem_valid = 0;
        exp_if_rdata = 32'h777; exp_mem_rdata = '0;
        p_if_req = 0; p_if_flush = 0; p_if_valid = 0; p_if_addr = '0;
        p_mem_req = 0; p_mem_we = 0; p_mem_valid = 0; p_mem_be = '0;
        p_mem_addr = '0; p_mem_wdata = '0;
        finished = 0;
        cyc = 0;

        while (!finished && cyc < RAND_LIMIT) begin
            applyStimulus(1);
            cyc++;

            // Expected bus state this cycle from the arbitration rules
            if (pe_bus && !p_ready) begin
                e_bus = 1;
            end else if (pe_bus) begin
                e_bus = 0;
            end else begin
                if (p_mem_req && !p_mem_valid)                    owner = 2;
                else if (p_if_req && !p_if_flush && !p_if_valid)  owner = 1;
                else                                              owner = 0;
                e_bus = (owner != 0);
                if (owner == 2) begin
                    txn_we    = p_mem_we;
                    txn_be    = p_mem_we ? p_mem_be : 4'hF;
                    txn_addr  = p_mem_addr;
                    txn_wdata = p_mem_wdata;
                end else if (owner == 1) begin
                    txn_we    = 0;
                    txn_be    = 4'hF;
                    txn_addr  = p_if_addr;
                end
                if (owner != 0) begin
                    lat_cnt     = $urandom_range(0, 7);
                    txn_flushed = 0;
                end
            end

            checkOutput("rnd_bus_req", bus_req, e_bus);
            if (e_bus) begin
                checkOutput("rnd_bus_addr", bus_addr, txn_addr);
                checkOutput("rnd_bus_we",   bus_we,   txn_we);
                checkOutput("rnd_bus_be",   bus_be,   txn_be);
                if (txn_we) checkOutput("rnd_bus_wdata", bus_wdata, txn_wdata);
            end
            checkOutput("rnd_if_valid",  if_valid,  exp_if_valid);
            checkOutput("rnd_mem_valid", mem_valid, exp_mem_valid);
            checkOutput("rnd_if_rdata",  if_rdata,  exp_if_rdata);
            checkOutput("rnd_mem_rdata", mem_rdata, exp_mem_rdata);
            if (if_valid === 1'b1)  dut_if_valids++;
            if (mem_valid === 1'b1) dut_mem_valids++;

            cur_if_v      = exp_if_valid;
            cur_mem_v     = exp_mem_valid;
            exp_if_valid  = 0;
            exp_mem_valid = 0;

            // MEM requester: holds until served, may advance on the valid cycle
            if (mem_active && cur_mem_v) mem_active = 0;
            if (!mem_active) begin
                if ((if_issued + mem_issued) < REQS && $urandom_range(0, 3) == 0) begin
                    mem_active = 1;
                    mem_issued++;
                    mem_req   = 1'b1;
                    mem_we    = 1'($urandom_range(0, 1));
                    mem_be    = 4'($urandom);
                    mem_addr  = 32'($urandom_range(0, 15)) << 2;
                    mem_wdata = $urandom;
                end else begin
                    mem_req = 1'b0;
                end
            end

            // IF requester: holds until served or squashed by a flush
            if_flush = 1'b0;
            if (if_active && cur_if_v) if_active = 0;
            if (if_active && $urandom_range(0, 11) == 0) begin
                if_flush  = 1'b1;
                if_active = 0;
                if_flushed++;
            end else if (!if_active) begin
                if ((if_issued + mem_issued) < REQS && $urandom_range(0, 2) != 0) begin
                    if_active = 1;
                    if_issued++;
                    if_req  = 1'b1;
                    if_addr = 32'($urandom_range(0, 15)) << 2;
                end else begin
                    if_req = 1'b0;
                end
            end

            // Memory responder with random latency, backed by the word array
            if (e_bus) begin
                if (owner == 1 && if_flush) txn_flushed = 1;
                if (lat_cnt == 0) begin
                    bus_ready = 1'b1;
                    rd        = mem_model[txn_addr[5:2]];
                    bus_rdata = rd;
                    if (owner == 2) begin
                        exp_mem_valid = 1;
                        if (txn_we) begin
                            for (int b = 0; b < 4; b++)
                                if (txn_be[b]) mem_model[txn_addr[5:2]][b*8 +: 8] = txn_wdata[b*8 +: 8];
                        end else begin
                            exp_mem_rdata = rd;
                        end
                    end else if (!txn_flushed) begin
                        exp_if_valid = 1;
                        exp_if_rdata = rd;
                    end
                end else begin
                    bus_ready = 1'b0;
                    bus_rdata = $urandom;
                    lat_cnt--;
                end
            end else begin
                bus_ready = 1'b0;
                bus_rdata = $urandom;
            end

            pe_bus      = e_bus;
            p_ready     = bus_ready;
            p_if_req    = if_req;
            p_if_flush  = if_flush;
            p_if_addr   = if_addr;
            p_if_valid  = cur_if_v;
            p_mem_req   = mem_req;
            p_mem_we    = mem_we;
            p_mem_be    = mem_be;
            p_mem_addr  = mem_addr;
            p_mem_wdata = mem_wdata;
            p_mem_valid = cur_mem_v;

            finished = ((if_issued + mem_issued) >= REQS) && !if_active && !mem_active &&
                       !e_bus && !exp_if_valid && !exp_mem_valid;
        end

        checkOutput("rnd_completed_in_budget", finished, 1);
        if_req    = 1'b0;
        if_flush  = 1'b0;
        mem_req   = 1'b0;
        bus_ready = 1'b0;
        applyStimulus(2);
        checkOutput("rnd_quiet_bus_req", bus_req,  0);
        checkOutput("rnd_mem_valid_count", dut_mem_valids, mem_issued);
        checkOutput("rnd_if_valid_count",  dut_if_valids,  if_issued - if_flushed);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-ported unified memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (loads and stores).
- Registers each granted request onto the bus and holds it until the memory acknowledges.
- Returns read data to the requester with a one-cycle valid pulse.
- Drives the stall signals that the pipeline hazard logic ORs into PCWrite, IFIDWrite and bubble generation.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_valid or if_flush
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  squash the in-flight or pending fetch (taken jump/branch)
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle completion pulse for the fetch
- mem_req  in  1  data request; held stable until mem_valid
- mem_we  in  1  1 = store, 0 = load
- mem_be  in  DATA_W/8  store byte enables
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, valid with mem_valid
- mem_valid  out  1  one-cycle completion pulse, loads and stores alike
- bus_req  out  1  bus transaction active
- bus_we  out  1  bus write
- bus_be  out  DATA_W/8  bus byte enables; all ones on reads
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_ready  in  1  memory accept/complete, any latency ≥0 cycles after bus_req
- bus_rdata  in  DATA_W  read data, sampled when bus_ready=1
- stall_if  out  1  IF must hold: if_req & ~if_valid & ~if_flush
- stall_mem  out  1  MEM must hold: mem_req & ~mem_valid

## Operation
FSM states: IDLE, BUS_IF, BUS_MEM.

- **IDLE**
  - mem_req=1 → latch MEM address/we/be/wdata into bus registers, go to BUS_MEM. Data always wins: it belongs to the older instruction.
  - Else if_req=1 and if_flush=0 → latch if_addr, go to BUS_IF.
  - Else stay in IDLE.
- **BUS_IF / BUS_MEM**
  - bus_req=1; bus outputs come from registers and stay constant until bus_ready.
  - On bus_ready → capture bus_rdata into the requester's rdata register, pulse that requester's valid next cycle, return to IDLE.
- **Flush**
  - Drop flag: set when if_flush=1 in BUS_IF. Cleared on entry to BUS_IF.
  - Flush during BUS_IF does not abort the bus transaction; it completes, but if_valid is suppressed and if_rdata is not updated.
  - if_flush in IDLE or BUS_MEM has no effect beyond masking stall_if.
- **Fairness**: no starvation counter. The pipeline cannot issue back-to-back MEM requests without IF fetches in between.
- **Stores**: mem_valid pulses on completion; mem_rdata is not updated.
- **Reset values**: state IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, if_valid=0, mem_valid=0, if_rdata=0, mem_rdata=0, drop flag=0.
- **Reset mid-transaction**: abandons the transaction immediately with bus_req=0. The memory side must tolerate this.

## Timing
- Grant: request seen in IDLE at cycle N → bus_req=1 from cycle N+1.
- Completion: bus_ready at cycle M → valid=1 at cycle M+1 with rdata stable; FSM is in IDLE at M+1.
- Minimum round trip (bus_ready same cycle as bus_req): request at N, valid at N+2. The next grant decision is at N+2.
- Simultaneous if_req and mem_req in IDLE: MEM granted. IF is granted at the first IDLE cycle after MEM completes, at the earliest M+1.
- Requester still asserting req in the cycle its valid pulses: treated as complete, not re-granted that cycle. Requesters must drop or advance req after valid. The arbiter ignores a req in the cycle its own valid is high.
- stall_if and stall_mem are combinational from req/valid/flush. They have no path from bus_ready.

## Structure
- Shared pipeline package holds:
  - ADDR_W and DATA_W defaults
  - the FSM state enum (ARB_IDLE, ARB_BUS_IF, ARB_BUS_MEM)
  - the all-ones byte-enable constant
- Single module, no sub-modules. Bus registers, FSM, drop flag and return registers are all in one file.

## Test plan
- Fetch only, bus_ready tied 1: if_req at addr 0x0000_0010, bus_rdata 0x0000_0013 → bus_addr 0x10 at N+1, if_valid and if_rdata=0x13 at N+2, stall_if high N..N+1.
- Collision: if_req (0x20) and mem_req load (0x100) at the same cycle, ready after 3 wait cycles → MEM served first. mem_valid at N+5, then IF granted at N+5, if_valid at N+10.
- Store: mem_we=1, be=4'b0011, addr 0x200, wdata 0xDEADBEEF → bus_we=1 and bus_be=0011 held through wait states. mem_valid pulses once; mem_rdata unchanged.
- Flush in flight: fetch granted, if_flush at N+2, ready at N+4 → no if_valid, if_rdata unchanged. New fetch granted at N+5.
- Reset mid-transaction: rst_n low during BUS_MEM with 5 wait cycles → all outputs at reset values immediately. After release, a fresh if_req is granted normally.
- Random ready latency 0-7, 1000 mixed requests → every req gets exactly one valid, in the arbitration order. Bus outputs are stable while bus_req=1 and bus_ready=0.
